// File: rtl/policy_selector.sv
// Epsilon-greedy action selector: scans four Q-values for state S, picks argmax or a random action.
// Optional exploration branch (LFSR + eps) enabled by defining INTELLIGHT_EXPLORE_EN.
module policy_selector #(
    parameter int L_WIDTH = 4,
    parameter int Q_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [L_WIDTH*2-1:0]      S,
    input  logic [7:0]                eps,
    input  logic                      seed_ld,
    input  logic [15:0]               seed,
    output logic                      q_rd_en,
    output logic [L_WIDTH*2+1:0]      q_addr,
    input  logic signed [Q_WIDTH-1:0] q_rd_data,
    output logic [L_WIDTH/2+1:0]      A,
    output logic                      A_valid,
    output logic                      explore,
    output logic                      busy
);

    localparam int SW = L_WIDTH * 2;
    localparam int AW = L_WIDTH / 2 + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [SW-1:0]             s_l;
    logic [1:0]                cnt;
    logic                      rd_valid;
    logic [1:0]                rd_idx;
    logic signed [Q_WIDTH-1:0] max_q;
    logic [1:0]                max_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (cnt == 2'd3) state_nx = DRAIN;
            DRAIN:   state_nx = DECIDE;
            DECIDE:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign A_valid = (state == DONE);

`ifdef INTELLIGHT_EXPLORE_EN
    logic [15:0] lfsr;
    logic [7:0]  eps_l;
    logic        fb;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr  <= 16'hACE1;
            eps_l <= '0;
        end else if (seed_ld) begin
            lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        end else if (state == IDLE && start) begin
            lfsr  <= {lfsr[14:0], fb};
            eps_l <= eps;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{eps, seed_ld, seed};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_l      <= '0;
            cnt      <= '0;
            q_rd_en  <= 1'b0;
            q_addr   <= '0;
            rd_valid <= 1'b0;
            rd_idx   <= '0;
            max_q    <= '0;
            max_idx  <= '0;
            A        <= '0;
            explore  <= 1'b0;
        end else begin
            rd_valid <= q_rd_en;
            rd_idx   <= q_addr[1:0];
            // Index 0 seeds the max; strict compare keeps the lowest index on ties.
            if (rd_valid && (rd_idx == 2'd0 || q_rd_data > max_q)) begin
                max_q   <= q_rd_data;
                max_idx <= rd_idx;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        s_l     <= S;
                        cnt     <= 2'd0;
                        q_rd_en <= 1'b1;
                        q_addr  <= {S, 2'b00};
                    end
                end
                FETCH: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) q_rd_en <= 1'b0;
                    else             q_addr  <= {s_l, cnt + 2'd1};
                end
                DECIDE: begin
`ifdef INTELLIGHT_EXPLORE_EN
                    if (lfsr[7:0] < eps_l) begin
                        A       <= AW'(lfsr[9:8]);
                        explore <= 1'b1;
                    end else begin
                        A       <= AW'(max_idx);
                        explore <= 1'b0;
                    end
`else
                    A       <= AW'(max_idx);
                    explore <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_policy_selector.sv
// Directed bench for policy_selector: greedy, ties, exploration, busy rejection, reset abort.
module tb_policy_selector;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         S;
    logic [7:0]         eps;
    logic               seed_ld;
    logic [15:0]        seed;
    logic               q_rd_en;
    logic [9:0]         q_addr;
    logic signed [15:0] q_rd_data;
    logic [3:0]         A;
    logic               A_valid;
    logic               explore;
    logic               busy;

    logic signed [15:0] qv [4];
    int n_cmp = 0;
    int n_err = 0;
    int av_cnt = 0;

    policy_selector #(.L_WIDTH(4), .Q_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .S(S), .eps(eps),
        .seed_ld(seed_ld), .seed(seed), .q_rd_en(q_rd_en),
        .q_addr(q_addr), .q_rd_data(q_rd_data), .A(A),
        .A_valid(A_valid), .explore(explore), .busy(busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency Q-table
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qv[q_addr[1:0]];
        else         q_rd_data <= 16'sd0;
    end

    always @(negedge clk) if (A_valid) av_cnt++;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_check(string nm, logic [7:0] s, logic [7:0] e,
                             logic signed [15:0] q0, logic signed [15:0] q1,
                             logic signed [15:0] q2, logic signed [15:0] q3,
                             logic [3:0] exp_a, logic exp_x);
        int lat;
        qv[0] = q0; qv[1] = q1; qv[2] = q2; qv[3] = q3;
        S = s; eps = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_addr%0d", nm, k), 32'(q_addr), 32'({s, 2'(k)}));
            check($sformatf("%s_rden%0d", nm, k), 32'(q_rd_en), 32'd1);
            @(negedge clk);
        end
        check({nm, "_rden_off"}, 32'(q_rd_en), 32'd0);
        lat = 5;
        while (!A_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd7);
        check({nm, "_A"}, 32'(A), 32'(exp_a));
        check({nm, "_explore"}, 32'(explore), 32'(exp_x));
        check({nm, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({nm, "_pulse_end"}, 32'(A_valid), 32'd0);
        check({nm, "_idle"}, 32'(busy), 32'd0);
        check({nm, "_A_held"}, 32'(A), 32'(exp_a));
    endtask

    task automatic load_seed(logic [15:0] v);
        seed = v; seed_ld = 1'b1;
        @(negedge clk);
        seed_ld = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int av0;
        rst = 1'b0; start = 1'b0; S = '0; eps = '0;
        seed_ld = 1'b0; seed = '0;
        qv[0] = 0; qv[1] = 0; qv[2] = 0; qv[3] = 0;
        repeat (2) @(negedge clk);
        check("rst_A", 32'(A), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rden", 32'(q_rd_en), 32'd0);
        check("rst_addr", 32'(q_addr), 32'd0);
        check("rst_av", 32'(A_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_check("greedy", 8'h3A, 8'd0, 16'sd5, -16'sd2, 16'sd17, 16'sd9, 4'd2, 1'b0);
        run_check("tie", 8'h5C, 8'd0, -16'sd7, -16'sd3, -16'sd3, -16'sd9, 4'd1, 1'b0);
        run_check("allmin", 8'hC3, 8'd0, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 4'd0, 1'b0);
        run_check("last", 8'h01, 8'd0, 16'sd0, 16'sd1, 16'sd2, 16'sd32767, 4'd3, 1'b0);

        load_seed(16'h0001);
`ifdef INTELLIGHT_EXPLORE_EN
        run_check("explore", 8'h77, 8'd255, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 4'd0, 1'b1);
`else
        run_check("explore", 8'h77, 8'd255, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 4'd3, 1'b0);
`endif
        load_seed(16'h0000);
`ifdef INTELLIGHT_EXPLORE_EN
        run_check("seed0", 8'h42, 8'd255, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 4'd1, 1'b1);
`else
        run_check("seed0", 8'h42, 8'd255, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 4'd3, 1'b0);
`endif

        // Second start at E3 must be dropped
        qv[0] = 16'sd3; qv[1] = 16'sd8; qv[2] = 16'sd1; qv[3] = 16'sd2;
        av0 = av_cnt;
        S = 8'h11; eps = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_one_av", 32'(av_cnt - av0), 32'd1);
        check("busy_low", 32'(busy), 32'd0);
        check("busy_A", 32'(A), 32'd1);

        // Reset asserted just after E3
        qv[0] = 16'sd0; qv[1] = 16'sd0; qv[2] = 16'sd9; qv[3] = 16'sd0;
        av0 = av_cnt;
        S = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_A", 32'(A), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_rden", 32'(q_rd_en), 32'd0);
        check("mid_addr", 32'(q_addr), 32'd0);
        check("mid_explore", 32'(explore), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_no_av", 32'(av_cnt - av0), 32'd0);
        run_check("post_rst", 8'h22, 8'd0, 16'sd0, 16'sd0, 16'sd9, 16'sd0, 4'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
